tmds_decode: RTL
================

// Module: tmds_decode
// PURPOSE
//  Receive-side counterpart of the DVI TMDS encoder: one channel of 10-bit TMDS symbols in, 8-bit pixel
//  data plus c0/c1/de out. The symbols come from an external 1:10 deserializer.
//  Word alignment: watches for control-token runs and pulses bitslip to the deserializer until locked.
//  One instance per channel; the blue instance recovers hsync (c0) and vsync (c1).
// PARAMETERS
//  CTRL_RUN        8      consecutive identical control tokens required to declare lock
//  SEARCH_TIMEOUT  4096   cycles in SEARCH without reaching CTRL_RUN before a bitslip is issued
//  SLIP_WAIT       16     cycles to wait after a bitslip pulse for the deserializer to settle
//  LOCK_TIMEOUT    16384  cycles in LOCKED with no control token before lock is dropped
// PORTS
//  clk       in   1   pixel clock; din is synchronous to it
//  reset     in   1   asynchronous reset, active-high
//  din       in   10  TMDS symbol; din[0] is the first bit on the wire
//  dout      out  8   decoded pixel byte (valid when de=1, else 8'h00)
//  c0        out  1   control bit 0 (hsync on the blue channel)
//  c1        out  1   control bit 1 (vsync on the blue channel)
//  de        out  1   data enable: 1 = video data symbol
//  bitslip   out  1   one-cycle pulse: deserializer shifts word boundary by 1 bit
//  aligned   out  1   1 while FSM is in LOCKED
// BEHAVIOUR
//  Reset (async, active-high): dout=0, c0=0, c1=0, de=0, bitslip=0, aligned=0; FSM=SEARCH;
//   all counters=0; pipeline registers cleared.
//  Token classification of din (combinational on the stage-1 register):
//   10'b1101010100 -> {c1,c0}=00
//   10'b0010101011 -> {c1,c0}=01
//   10'b0101010100 -> {c1,c0}=10
//   10'b1010101011 -> {c1,c0}=11
//   anything else  -> data symbol
//  Data decode:
//   d[7:0] = din[9] ? ~din[7:0] : din[7:0]
//   dout[0] = d[0]
//   dout[i] = din[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i=1..7
//  Pipeline: din is registered at edge N (stage 1), then decoded and registered at edge N+1.
//   dout/c0/c1/de reflect that symbol after edge N+1, i.e. 2-cycle latency, every cycle, no stall.
//  Control symbol: de=0, dout=0, c0/c1 set from the token.
//  Data symbol: de=1, dout=decoded byte, c0/c1 hold their last control value.
//  Decode outputs are produced regardless of aligned; downstream gates on aligned.
//  FSM states SEARCH, SLIP, LOCKED. Counters: run_cnt, tmo_cnt, wait_cnt.
//   SEARCH: run_cnt +1 if the current token equals the previous token, else reload to 1 (or 0 on data).
//    tmo_cnt +1 every cycle.
//    run_cnt==CTRL_RUN -> LOCKED, clear tmo_cnt.
//    Otherwise tmo_cnt==SEARCH_TIMEOUT-1 -> bitslip=1 for exactly 1 cycle, go to SLIP, clear counters.
//    If both happen in the same cycle, lock wins and no bitslip is issued.
//   SLIP: bitslip=0; wait_cnt counts to SLIP_WAIT-1, then back to SEARCH with run_cnt=tmo_cnt=0.
//    Symbols arriving in SLIP are decoded but ignored by the FSM.
//   LOCKED: aligned=1. tmo_cnt clears on any control token, else +1.
//    tmo_cnt==LOCK_TIMEOUT-1 -> SEARCH, aligned=0 on the next cycle, counters cleared.
//  Counter widths are clog2(param)+1. Counters saturate at their terminal value and never wrap.
//  bitslip is never asserted twice within SLIP_WAIT+1 cycles.
//  Reset asserted mid-operation returns everything to the reset state immediately (async),
//   including a bitslip pulse that is in flight.
// TESTING
//  1. Feed 10'b1101010100 x8, then encoder output for 8'hA5.
//     -> aligned=1 two cycles after the 8th token; de=1, dout=8'hA5 two cycles after the data symbol.
//  2. Loop through all 256 bytes via a reference encoder (disparity running, DC balanced).
//     -> dout matches input, de=1, zero mismatches.
//  3. Cycle tokens 00/01/10/11 with de low. -> {c1,c0}=00,01,10,11 in order at 2-cycle latency;
//     c0/c1 hold through a subsequent data burst.
//  4. Feed a token stream rotated 3 bits, with the model deserializer rotating back 1 bit per bitslip.
//     -> exactly 3 bitslip pulses, each SEARCH_TIMEOUT+SLIP_WAIT cycles apart; then aligned=1.
//  5. Locked, then data-only symbols for 16384 cycles. -> aligned falls; SEARCH restarts;
//     no bitslip before another 4096 cycles.
//  6. Assert reset during SLIP and during LOCKED. -> all outputs 0 at once; relock after 8 tokens
//     once reset is released.

Source files
------------

// File: rtl/tmds_decode.sv
// TMDS receive channel: token/data decode with 2-cycle latency and a
// control-token word aligner that drives the deserializer bitslip.
module tmds_decode #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16,
  parameter int LOCK_TIMEOUT   = 16384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       bitslip,
  output logic       aligned
);

  localparam int TMAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ?
                        SEARCH_TIMEOUT : LOCK_TIMEOUT;
  localparam int RW = $clog2(CTRL_RUN) + 1;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int WW = $clog2(SLIP_WAIT) + 1;

  localparam logic [RW-1:0] RUN_LOCK  = RW'(CTRL_RUN);
  localparam logic [TW-1:0] SRCH_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } state_t;

  state_t        state;
  logic [9:0]    sym;
  logic          is_ctrl;
  logic [1:0]    tok;
  logic [7:0]    d;
  logic [7:0]    dec;
  logic          prev_ctrl;
  logic [1:0]    prev_tok;
  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] wait_cnt;

  always_comb begin
    is_ctrl = 1'b1;
    tok     = 2'b00;
    unique case (sym)
      10'b1101010100: tok = 2'b00;
      10'b0010101011: tok = 2'b01;
      10'b0101010100: tok = 2'b10;
      10'b1010101011: tok = 2'b11;
      default:        is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    d      = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = 8'h00;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++)
      dec[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  // Run length of identical control tokens; data breaks the run.
  always_comb begin
    if (!is_ctrl)
      run_nxt = '0;
    else if (prev_ctrl && tok == prev_tok)
      run_nxt = (run_cnt == RUN_LOCK) ? run_cnt : run_cnt + 1'b1;
    else
      run_nxt = RW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym  <= '0;
      dout <= '0;
      c0   <= 1'b0;
      c1   <= 1'b0;
      de   <= 1'b0;
    end else begin
      sym <= din;
      if (is_ctrl) begin
        de        <= 1'b0;
        dout      <= '0;
        {c1, c0}  <= tok;
      end else begin
        de   <= 1'b1;
        dout <= dec;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      run_cnt   <= '0;
      tmo_cnt   <= '0;
      wait_cnt  <= '0;
      prev_ctrl <= 1'b0;
      prev_tok  <= 2'b00;
      bitslip   <= 1'b0;
      aligned   <= 1'b0;
    end else begin
      bitslip   <= 1'b0;
      prev_ctrl <= is_ctrl;
      prev_tok  <= tok;
      case (state)
        SEARCH: begin
          run_cnt <= run_nxt;
          if (tmo_cnt != SRCH_LAST)
            tmo_cnt <= tmo_cnt + 1'b1;
          if (run_nxt == RUN_LOCK) begin
            state   <= LOCKED;
            aligned <= 1'b1;
            run_cnt <= '0;
            tmo_cnt <= '0;
          end else if (tmo_cnt == SRCH_LAST) begin
            state    <= SLIP;
            bitslip  <= 1'b1;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            wait_cnt <= '0;
          end
        end
        SLIP: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= SEARCH;
            wait_cnt <= '0;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (is_ctrl) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == LOCK_LAST) begin
            state   <= SEARCH;
            aligned <= 1'b0;
            tmo_cnt <= '0;
            run_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state   <= SEARCH;
          aligned <= 1'b0;
        end
      endcase
    end
  end

endmodule
